// File: rtl/comparador_sequencia_jogadas_if.sv
// rtl/comparador_sequencia_jogadas_if.sv - play-sequence comparator control, play and status bundle
interface comparador_sequencia_jogadas_if #(
    parameter int LARGURA      = 4,
    parameter int PROFUNDIDADE = 16
);
    localparam int IND = $clog2(PROFUNDIDADE);

    logic               limpa;
    logic               grava;
    logic [LARGURA-1:0] dado_gravado;
    logic               iniciar;
    logic [LARGURA-1:0] jogada;
    logic               jogada_valida;

    logic               igual;
    logic               diferente;
    logic               fim_acerto;
    logic               fim_erro;
    logic [IND-1:0]     indice;
    logic [IND:0]       carregados;
    logic               cheio;
    logic               comparando;

    // game FSM / play-input side
    modport master (
        output limpa, grava, dado_gravado, iniciar, jogada, jogada_valida,
        input  igual, diferente, fim_acerto, fim_erro, indice, carregados, cheio, comparando
    );

    // comparator side
    modport slave (
        input  limpa, grava, dado_gravado, iniciar, jogada, jogada_valida,
        output igual, diferente, fim_acerto, fim_erro, indice, carregados, cheio, comparando
    );
endinterface

// File: rtl/comparador_sequencia_jogadas.sv
// rtl/comparador_sequencia_jogadas.sv - stores a reference play sequence and checks player plays against it
module comparador_sequencia_jogadas #(
    parameter int LARGURA      = 4,
    parameter int PROFUNDIDADE = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    comparador_sequencia_jogadas_if.slave bus
);
    localparam int IND = $clog2(PROFUNDIDADE);
    localparam logic [IND:0] MAX_CARGA = (IND+1)'(PROFUNDIDADE);

    typedef enum logic [1:0] {
        CARGA   = 2'd0,
        COMPARA = 2'd1,
        ACERTOU = 2'd2,
        ERROU   = 2'd3
    } estado_t;

    estado_t            estado, estado_n;
    logic [IND:0]       carregados, carregados_n;
    logic [IND-1:0]     indice, indice_n;
    logic               igual, igual_n;
    logic               diferente, diferente_n;
    logic               escreve;
    logic               cheio;
    logic               ultima;
    logic [LARGURA-1:0] referencia;

    // contents are never reset; carregados alone says which entries are valid
    logic [LARGURA-1:0] mem [0:PROFUNDIDADE-1];

    assign cheio      = (carregados == MAX_CARGA);
    assign referencia = mem[indice];
    assign ultima     = ({1'b0, indice} == (carregados - 1'b1));

    always_ff @(posedge clock) begin
        if (escreve) begin
            mem[carregados[IND-1:0]] <= bus.dado_gravado;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado     <= CARGA;
            carregados <= '0;
            indice     <= '0;
            igual      <= 1'b0;
            diferente  <= 1'b0;
        end else begin
            estado     <= estado_n;
            carregados <= carregados_n;
            indice     <= indice_n;
            igual      <= igual_n;
            diferente  <= diferente_n;
        end
    end

    always_comb begin
        estado_n     = estado;
        carregados_n = carregados;
        indice_n     = indice;
        igual_n      = 1'b0;
        diferente_n  = 1'b0;
        escreve      = 1'b0;

        if (bus.limpa) begin
            estado_n     = CARGA;
            carregados_n = '0;
            indice_n     = '0;
        end else begin
            case (estado)
                CARGA: begin
                    if (bus.grava && !cheio) begin
                        escreve      = 1'b1;
                        carregados_n = carregados + 1'b1;
                    end
                    if (bus.iniciar && (carregados != '0)) begin
                        estado_n = COMPARA;
                        indice_n = '0;
                    end
                end
                COMPARA: begin
                    // a restart outranks a play arriving in the same cycle
                    if (bus.iniciar) begin
                        indice_n = '0;
                    end else if (bus.jogada_valida) begin
                        if (bus.jogada == referencia) begin
                            igual_n = 1'b1;
                            if (ultima) begin
                                estado_n = ACERTOU;
                            end else begin
                                indice_n = indice + 1'b1;
                            end
                        end else begin
                            diferente_n = 1'b1;
                            estado_n    = ERROU;
                        end
                    end
                end
                ACERTOU, ERROU: begin
                    if (bus.iniciar) begin
                        estado_n = COMPARA;
                        indice_n = '0;
                    end
                end
                default: begin
                    estado_n = CARGA;
                end
            endcase
        end
    end

    assign bus.igual      = igual;
    assign bus.diferente  = diferente;
    assign bus.fim_acerto = (estado == ACERTOU);
    assign bus.fim_erro   = (estado == ERROU);
    assign bus.indice     = indice;
    assign bus.carregados = carregados;
    assign bus.cheio      = cheio;
    assign bus.comparando = (estado == COMPARA);
endmodule

// File: doc/comparador_sequencia_jogadas.md
Name: comparador_sequencia_jogadas

Overview:
Parametrised, registered successor to the single-play comparator. Stores a reference sequence of up to PROFUNDIDADE plays, each LARGURA bits wide, then checks a stream of player plays against it one by one. Reports a per-play match or mismatch, the current position and the final outcome. Sits between the play-input logic and the game FSM, which only handles start, clear and the outcome flags.

Parameters:
LARGURA, 4, bit width of one play.
PROFUNDIDADE, 16, maximum sequence length (power of two, ≥2).
Internal: IND = clog2(PROFUNDIDADE). Counts use IND+1 bits.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high; returns block to reset state.
limpa  in  1  synchronous clear of the stored sequence; any state -> CARGA.
grava  in  1  one-cycle pulse; appends dado_gravado to the sequence (CARGA only).
dado_gravado  in  LARGURA  reference play to store.
iniciar  in  1  one-cycle pulse; starts or restarts the comparison.
jogada  in  LARGURA  player play.
jogada_valida  in  1  one-cycle pulse qualifying jogada.
igual  out  1  registered, one-cycle pulse: last play matched.
diferente  out  1  registered, one-cycle pulse: last play mismatched.
fim_acerto  out  1  level: whole sequence matched.
fim_erro  out  1  level: a mismatch ended the round.
indice  out  IND  position of the next play to compare.
carregados  out  IND+1  number of stored plays.
cheio  out  1  carregados == PROFUNDIDADE.
comparando  out  1  high in state COMPARA.

Behaviour:
- Storage: PROFUNDIDADE x LARGURA register array written at address carregados[IND-1:0]. No reset on contents; validity is tracked only by carregados.
- Reset (async): state CARGA, carregados=0, indice=0, all flags 0, igual=diferente=0.
- States:
  - CARGA
    - grava && !cheio -> store the play, carregados+1.
    - grava when cheio -> ignored, no wrap-around.
    - iniciar && carregados>0 -> COMPARA, indice=0.
    - iniciar when carregados==0 -> ignored.
    - jogada_valida ignored.
  - COMPARA, on jogada_valida:
    - jogada == mem[indice] -> igual pulses next cycle.
      - indice == carregados-1 -> ACERTOU.
      - otherwise indice+1.
    - jogada != mem[indice] -> diferente pulses next cycle; go to ERROU; indice holds the failing position.
    - grava ignored.
    - iniciar restarts at indice=0 with no igual/diferente pulse. If both pulses arrive in the same cycle, iniciar wins and the play is discarded.
  - ACERTOU
    - fim_acerto=1, held.
    - iniciar -> COMPARA, indice=0, flag cleared the same edge.
    - grava and jogada_valida ignored.
  - ERROU
    - fim_erro=1, held.
    - iniciar -> COMPARA, indice=0, flag cleared.
    - grava and jogada_valida ignored.
- limpa has priority over every other input in every state:
  - -> CARGA, carregados=0, indice=0, flags cleared.
  - A play in the same cycle is discarded; no pulse.
- Latency:
  - igual/diferente are asserted exactly 1 cycle after the jogada_valida edge, for exactly 1 cycle.
  - fim_acerto/fim_erro rise on the same edge as the final igual/diferente.
- Comparison is full-width equality on LARGURA bits. Outside COMPARA no comparison occurs (the enable behaviour of the previous block).
- igual and diferente are never high together. fim_acerto and fim_erro are never high together.
- reset mid-round aborts immediately; the sequence must be reloaded.

Test Plan:
- Reset then load 3,7,A; iniciar; plays 3,7,A -> igual on 3 consecutive plays, indice 0→1→2, fim_acerto=1 with last igual, carregados=3.
- Same sequence; plays 3,5 -> igual, then diferente; fim_erro=1, indice=1; a further jogada_valida causes no pulse.
- Load 16 plays with PROFUNDIDADE=16, then a 17th grava -> cheio=1, carregados stays 16, mem[0] unchanged; full 16-play match -> fim_acerto.
- iniciar with carregados=0 -> stays CARGA, comparando=0. iniciar and jogada_valida in the same COMPARA cycle -> indice=0, no igual/diferente.
- Mid-round (indice=2): limpa and jogada_valida together -> CARGA, carregados=0, no pulse. Async reset asserted mid-cycle -> outputs 0 before the next edge.
- After fim_erro, iniciar -> fim_erro drops, indice=0; replaying the correct sequence -> fim_acerto without reloading.
